instruction_queue: RTL and testbench
====================================

// Module: instruction_queue
// PURPOSE
//  In-order instruction queue and dispatcher sitting directly upstream of the adder and multiplier
//  reservation stations. Buffers 16-bit instructions from fetch and decodes the opcode of the head entry.
//  Issues the head to the matching RS when that RS reports a free line; issue is a one-cycle registered pulse.
//  Head-of-line blocking is intentional: issue is strictly in program order.
// PARAMETERS
//  DEPTH   8   queue entries (power of 2, >=2)
//  AW      3   log2(DEPTH); Count is AW+1 bits
// PORTS
//  Clock           in   1   single clock, all state on posedge
//  Reset           in   1   asynchronous, active-high; clears all state
//  InstIn          in   16  instruction from fetch: [3:0] opcode, [12:10] Rz, [9:7] Ry, [6:4] Rx
//  InstValid       in   1   InstIn valid this cycle
//  InstReady       out  1   queue can accept; push occurs when InstValid & InstReady at posedge
//  Flush           in   1   synchronous flush of queue contents
//  DisponivelAdd   in   1   adder RS has a free line
//  DisponivelMul   in   1   multiplier RS has a free line
//  Instruction     out  16  issued instruction, shared by both RSs
//  Adderin         out  1   one-cycle pulse: Instruction targets the adder RS
//  Mulin           out  1   one-cycle pulse: Instruction targets the multiplier RS
//  Count           out  AW+1  entries currently held
//  Empty / Full    out  1   Count==0 / Count==DEPTH
//  IllegalOp       out  1   one-cycle pulse: head had an undefined opcode and was discarded
//  Halted          out  1   HALT reached the head; dispatch stopped
//  StallCycles     out  16  saturating count of cycles a valid head waited on a busy RS
// BEHAVIOUR
//  Reset values: Instruction=0, Adderin=0, Mulin=0, IllegalOp=0, Halted=0, StallCycles=0, Count=0.
//   Rd/wr pointers are 0. State is RUN. Cooldown bits are 0.
//  Opcode classes (InstIn[3:0]):
//   ADD class: 0000, 0001, 0100, 0101
//   MUL class: 0010, 0011
//   HALT: 1111
//   All other opcodes are illegal.
//  Push: InstReady = ~Full, combinational from Count. A push while Full is ignored; there is no bypass.
//   The pushed entry is visible at the head on the cycle after the push edge.
//  Pop/issue decision is made at each posedge in state RUN with Count>0, evaluated on the head entry:
//   ADD & DisponivelAdd & ~cool_add -> pop; register Instruction=head, Adderin=1; set cool_add.
//   MUL & DisponivelMul & ~cool_mul -> pop; register Instruction=head, Mulin=1; set cool_mul.
//   illegal -> pop, IllegalOp=1, no issue; Instruction holds its previous value.
//   HALT -> pop, state goes to HALTED, Halted=1.
//   ADD or MUL whose RS is not available, or whose cooldown bit is set -> no pop; StallCycles++ (saturates at FFFF).
//  Cooldown: each cool bit self-clears one cycle after it is set. A given RS never sees its in-pulse on
//   two consecutive cycles, which covers the one-cycle lag of the Disponivel flags.
//   ADD then MUL back-to-back is allowed.
//  Latency: push at edge E0 gives issue pulse at the earliest at edge E1, high for exactly one cycle.
//   The RS samples the pulse at E2.
//  Adderin and Mulin are never both 1. At most one pop per cycle.
//  Simultaneous push and pop: Count unchanged; both pointers advance and wrap modulo DEPTH.
//   Push while Full is rejected even if a pop occurs in the same cycle.
//  Flush (sync): Count=0 and pointers=0. The pending issue pulse for this edge is suppressed.
//   State returns to RUN; cool bits clear. Flush has priority over push and pop in the same cycle.
//  HALTED: no further pops; pushes are still accepted until Full. Only Reset or Flush leave HALTED.
//  Reset asserted mid-operation clears immediately; any pulse in flight is dropped.
// TESTING
//  1. Push 0x1C01 (ADD) with DisponivelAdd=1 -> Adderin=1 and Instruction=0x1C01 one cycle later, for 1 cycle; Count back to 0.
//  2. Push two ADDs back-to-back with DisponivelAdd held 1 -> Adderin pulses on cycles N and N+2, never N+1; StallCycles=1.
//  3. Fill 8 entries with DisponivelAdd=0 -> Full=1, InstReady=0; 9th push is ignored;
//     then raise DisponivelAdd -> entries drain in push order, pointer wraps.
//  4. Queue ADD, opcode 0x7, MUL with DisponivelAdd=1 and DisponivelMul=1 -> Adderin, then IllegalOp, then Mulin on successive cycles.
//  5. Queue HALT then ADD -> Halted=1, ADD stays queued (Count=1); Flush -> Count=0, Halted=0.
//  6. Assert Reset during an Adderin pulse -> all outputs 0 asynchronously; Count=0 after release.

Source files
------------

// File: rtl/instruction_queue.sv
// In-order instruction queue feeding the adder/multiplier reservation stations; decodes the head opcode.
// Latency: push at edge E0 -> earliest one-cycle issue pulse at E1; at most one pop per cycle.
// Backpressure: InstReady = ~Full; head-of-line blocks on a busy RS or HALT, never reorders.
module instruction_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [15:0]   InstIn,
    input  logic          InstValid,
    output logic          InstReady,
    input  logic          Flush,
    input  logic          DisponivelAdd,
    input  logic          DisponivelMul,
    output logic [15:0]   Instruction,
    output logic          Adderin,
    output logic          Mulin,
    output logic [AW:0]   Count,
    output logic          Empty,
    output logic          Full,
    output logic          IllegalOp,
    output logic          Halted,
    output logic [15:0]   StallCycles
);

    typedef struct packed {
        logic [2:0] spare;
        logic [2:0] rz;
        logic [2:0] ry;
        logic [2:0] rx;
        logic [3:0] opcode;
    } inst_t;

    typedef enum logic [1:0] {
        CLS_ADD,
        CLS_MUL,
        CLS_HALT,
        CLS_ILL
    } op_class_t;

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    inst_t          mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    state_t         state;
    logic           cool_add;
    logic           cool_mul;

    inst_t          head;
    op_class_t      head_cls;
    logic           head_vld;
    logic           do_add;
    logic           do_mul;
    logic           do_ill;
    logic           do_halt;
    logic           stall;
    logic           push;
    logic           pop;

    function automatic op_class_t classify(input logic [3:0] op);
        op_class_t cls;
        case (op)
            4'h0, 4'h1, 4'h4, 4'h5: cls = CLS_ADD;
            4'h2, 4'h3:             cls = CLS_MUL;
            4'hF:                   cls = CLS_HALT;
            default:                cls = CLS_ILL;
        endcase
        return cls;
    endfunction

    assign Full      = (Count == FULL_CNT);
    assign Empty     = (Count == '0);
    assign InstReady = ~Full;

    // Head decode; the cool bits keep an RS from seeing two pulses before its free flag catches up.
    always_comb begin
        head     = mem[rd_ptr];
        head_cls = classify(head.opcode);
        head_vld = (state == RUN) && !Empty;
        do_add   = head_vld && (head_cls == CLS_ADD) && DisponivelAdd && !cool_add;
        do_mul   = head_vld && (head_cls == CLS_MUL) && DisponivelMul && !cool_mul;
        do_ill   = head_vld && (head_cls == CLS_ILL);
        do_halt  = head_vld && (head_cls == CLS_HALT);
        stall    = head_vld && (((head_cls == CLS_ADD) && !do_add) ||
                                ((head_cls == CLS_MUL) && !do_mul));
        pop      = do_add || do_mul || do_ill || do_halt;
        push     = InstValid && !Full;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !Flush) begin
            mem[wr_ptr] <= inst_t'(InstIn);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= RUN;
            Instruction <= '0;
            Adderin     <= 1'b0;
            Mulin       <= 1'b0;
            IllegalOp   <= 1'b0;
            Halted      <= 1'b0;
            StallCycles <= '0;
            Count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            cool_add    <= 1'b0;
            cool_mul    <= 1'b0;
        end else begin
            Adderin   <= 1'b0;
            Mulin     <= 1'b0;
            IllegalOp <= 1'b0;
            cool_add  <= 1'b0;
            cool_mul  <= 1'b0;
            if (Flush) begin
                state  <= RUN;
                Halted <= 1'b0;
                Count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                case (state)
                    RUN: begin
                        if (do_add) begin
                            Instruction <= head;
                            Adderin     <= 1'b1;
                            cool_add    <= 1'b1;
                        end
                        if (do_mul) begin
                            Instruction <= head;
                            Mulin       <= 1'b1;
                            cool_mul    <= 1'b1;
                        end
                        if (do_ill) begin
                            IllegalOp <= 1'b1;
                        end
                        if (do_halt) begin
                            state  <= HALTED;
                            Halted <= 1'b1;
                        end
                    end
                    HALTED: begin
                        Halted <= 1'b1;
                    end
                    default: begin
                        state <= RUN;
                    end
                endcase
                if (stall && (StallCycles != 16'hFFFF)) begin
                    StallCycles <= StallCycles + 16'd1;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                Count <= Count + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end

    a_one_target: assert property (@(posedge Clock) disable iff (Reset) !(Adderin && Mulin));
    a_count_range: assert property (@(posedge Clock) disable iff (Reset) Count <= FULL_CNT);
    a_add_spacing: assert property (@(posedge Clock) disable iff (Reset) Adderin |=> !Adderin);
    a_mul_spacing: assert property (@(posedge Clock) disable iff (Reset) Mulin |=> !Mulin);

endmodule

// File: tb/tb_instruction_queue.sv
// Randomized and directed stimulus for instruction_queue, checked against a queue-based reference model.
module tb_instruction_queue;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          Clock;
    logic          Reset;
    logic [15:0]   InstIn;
    logic          InstValid;
    logic          InstReady;
    logic          Flush;
    logic          DisponivelAdd;
    logic          DisponivelMul;
    logic [15:0]   Instruction;
    logic          Adderin;
    logic          Mulin;
    logic [AW:0]   Count;
    logic          Empty;
    logic          Full;
    logic          IllegalOp;
    logic          Halted;
    logic [15:0]   StallCycles;

    instruction_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .InstIn        (InstIn),
        .InstValid     (InstValid),
        .InstReady     (InstReady),
        .Flush         (Flush),
        .DisponivelAdd (DisponivelAdd),
        .DisponivelMul (DisponivelMul),
        .Instruction   (Instruction),
        .Adderin       (Adderin),
        .Mulin         (Mulin),
        .Count         (Count),
        .Empty         (Empty),
        .Full          (Full),
        .IllegalOp     (IllegalOp),
        .Halted        (Halted),
        .StallCycles   (StallCycles)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: program-order list of held instructions plus the expected issue stream.
    typedef struct {
        bit          add;
        bit          mul;
        bit          ill;
        logic [15:0] ins;
    } ev_t;

    logic [15:0] mq[$];
    ev_t         sb[$];
    bit          m_halted   = 0;
    bit          m_cool_add = 0;
    bit          m_cool_mul = 0;
    bit          m_add      = 0;
    bit          m_mul      = 0;
    bit          m_ill      = 0;
    int          m_stall    = 0;
    logic [15:0] m_last     = '0;

    function automatic bit is_add(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h4, 4'h5};
    endfunction

    function automatic bit is_mul(input logic [3:0] op);
        return op inside {4'h2, 4'h3};
    endfunction

    always @(posedge Clock) begin
        bit          was_full;
        bit          next_ca;
        bit          next_cm;
        logic [15:0] h;
        if (Reset) begin
            mq.delete();
            sb.delete();
            m_halted   = 0;
            m_cool_add = 0;
            m_cool_mul = 0;
            m_add      = 0;
            m_mul      = 0;
            m_ill      = 0;
            m_stall    = 0;
            m_last     = '0;
        end else begin
            was_full = (mq.size() == DEPTH);
            m_add    = 0;
            m_mul    = 0;
            m_ill    = 0;
            next_ca  = 0;
            next_cm  = 0;
            if (Flush) begin
                mq.delete();
                m_halted = 0;
            end else begin
                if (!m_halted && mq.size() != 0) begin
                    h = mq[0];
                    if (is_add(h[3:0])) begin
                        if (DisponivelAdd && !m_cool_add) begin
                            void'(mq.pop_front());
                            m_add   = 1;
                            m_last  = h;
                            next_ca = 1;
                            sb.push_back('{1'b1, 1'b0, 1'b0, h});
                        end else if (m_stall < 65535) begin
                            m_stall++;
                        end
                    end else if (is_mul(h[3:0])) begin
                        if (DisponivelMul && !m_cool_mul) begin
                            void'(mq.pop_front());
                            m_mul   = 1;
                            m_last  = h;
                            next_cm = 1;
                            sb.push_back('{1'b0, 1'b1, 1'b0, h});
                        end else if (m_stall < 65535) begin
                            m_stall++;
                        end
                    end else if (h[3:0] == 4'hF) begin
                        void'(mq.pop_front());
                        m_halted = 1;
                    end else begin
                        void'(mq.pop_front());
                        m_ill = 1;
                        sb.push_back('{1'b0, 1'b0, 1'b1, m_last});
                    end
                end
                if (InstValid && !was_full) begin
                    mq.push_back(InstIn);
                end
            end
            m_cool_add = next_ca;
            m_cool_mul = next_cm;
        end
    end

    // Monitor: per-cycle pulse/status comparison, plus scoreboard pop whenever the DUT issues.
    always @(posedge Clock) begin
        ev_t ev;
        #1;
        check("adderin", Adderin, m_add);
        check("mulin", Mulin, m_mul);
        check("illegalop", IllegalOp, m_ill);
        check("count", Count, mq.size());
        check("full", Full, mq.size() == DEPTH);
        check("empty", Empty, mq.size() == 0);
        check("instready", InstReady, mq.size() != DEPTH);
        check("halted", Halted, m_halted);
        check("stallcycles", StallCycles, m_stall);
        if (Adderin || Mulin || IllegalOp) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got add=%0b mul=%0b ill=%0b with no issue pending",
                         Adderin, Mulin, IllegalOp);
            end else begin
                ev = sb.pop_front();
                check("pulse_kind", {Adderin, Mulin, IllegalOp}, {ev.add, ev.mul, ev.ill});
                check("instruction", Instruction, ev.ins);
            end
        end
    end

    task automatic drive(input bit v, input logic [15:0] ins, input bit da, input bit dm, input bit fl);
        @(negedge Clock);
        InstValid     = v;
        InstIn        = ins;
        DisponivelAdd = da;
        DisponivelMul = dm;
        Flush         = fl;
    endtask

    task automatic idle(input int n, input bit da, input bit dm);
        repeat (n) drive(1'b0, 16'h0000, da, dm, 1'b0);
    endtask

    initial begin
        logic [15:0] stall0;
        logic [15:0] rnd;
        logic [3:0]  op;
        int          r;

        Reset = 1'b1;
        InstIn = '0;
        InstValid = 1'b0;
        Flush = 1'b0;
        DisponivelAdd = 1'b0;
        DisponivelMul = 1'b0;
        #1;
        check("rst_count", Count, 0);
        check("rst_instruction", Instruction, 0);
        check("rst_pulses", {Adderin, Mulin, IllegalOp, Halted}, 0);
        check("rst_stall", StallCycles, 0);
        check("rst_empty", Empty, 1);
        repeat (3) @(negedge Clock);
        Reset = 1'b0;

        // Single ADD issues one cycle after the push and drains the queue.
        drive(1'b1, 16'h1C01, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1, 1'b0);
        check("t1_count", Count, 0);
        check("t1_instruction", Instruction, 16'h1C01);

        // Two back-to-back ADDs: the cooldown forces exactly one stall cycle between pulses.
        stall0 = StallCycles;
        drive(1'b1, 16'h0011, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 16'h0480, 1'b1, 1'b0, 1'b0);
        idle(6, 1'b1, 1'b0);
        check("t2_stall_delta", StallCycles - stall0, 1);

        // Fill while the adder RS is busy; the ninth push must bounce.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, {8'(i), 4'h0, 4'h4}, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b1, 16'hBEE1, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0, 1'b0);
        check("t3_full", Full, 1);
        check("t3_instready", InstReady, 0);
        check("t3_count", Count, DEPTH);
        idle(2 * DEPTH + 4, 1'b1, 1'b0);
        check("t3_drained", Count, 0);
        check("t3_last", Instruction, {8'(DEPTH - 1), 4'h0, 4'h4});

        // ADD, illegal, MUL on successive cycles.
        drive(1'b1, 16'h0011, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 16'h0027, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 16'h0232, 1'b1, 1'b1, 1'b0);
        idle(5, 1'b1, 1'b1);
        check("t4_instruction", Instruction, 16'h0232);

        // HALT blocks the following ADD until Flush.
        drive(1'b1, 16'h000F, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 16'h0041, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1, 1'b1);
        check("t5_halted", Halted, 1);
        check("t5_count", Count, 1);
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        idle(1, 1'b1, 1'b1);
        check("t5_flush_count", Count, 0);
        check("t5_flush_halted", Halted, 0);

        // Reset landing on an Adderin pulse clears outputs without waiting for a clock.
        drive(1'b1, 16'h1C01, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        @(posedge Clock);
        #2;
        check("t6_pulse_before_reset", Adderin, 1);
        #1;
        Reset = 1'b1;
        #1;
        check("t6_adderin", Adderin, 0);
        check("t6_instruction", Instruction, 0);
        check("t6_count", Count, 0);
        check("t6_stall", StallCycles, 0);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        idle(2, 1'b0, 1'b0);
        check("t6_count_after", Count, 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            r   = int'($urandom_range(0, 99));
            rnd = 16'($urandom());
            if (r < 45)      op = {1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1))};
            else if (r < 85) op = {3'b001, 1'($urandom_range(0, 1))};
            else if (r < 97) op = 4'($urandom_range(6, 14));
            else             op = 4'hF;
            drive($urandom_range(0, 9) < 7, {rnd[15:4], op},
                  $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 24) == 0);
        end

        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        idle(20, 1'b1, 1'b1);
        check("final_scoreboard_empty", sb.size(), 0);
        check("final_count", Count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
